// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - register file write/read/alloc bus
interface regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              WE;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] WD;
  logic [ADDR_W-1:0] RA1;
  logic [ADDR_W-1:0] RA2;
  logic              ALLOC;
  logic [ADDR_W-1:0] ALLOC_A;
  logic [DATA_W-1:0] R1;
  logic [DATA_W-1:0] R2;
  logic              B1;
  logic              B2;
  logic              ANY_BUSY;

  modport master (
    output WE, WA, WD, RA1, RA2, ALLOC, ALLOC_A,
    input  R1, R2, B1, B2, ANY_BUSY
  );

  modport slave (
    input  WE, WA, WD, RA1, RA2, ALLOC, ALLOC_A,
    output R1, R2, B1, B2, ANY_BUSY
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write-first read ports and busy scoreboard
module regfile_sb #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 3,
  parameter int                ZERO_R0   = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic         CLK,
  input logic         RST_N,
  regfile_sb_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] mem;
  logic [NREG-1:0]             busy;
  logic [NREG-1:0]             busy_nxt;
  logic                        we_ok;
  logic                        alloc_ok;
  logic [DATA_W-1:0]           rd1;
  logic [DATA_W-1:0]           rd2;

  // Entry 0 is never written nor marked busy when hardwired, so it reads 0/0 without special casing.
  always_comb begin
    we_ok    = bus.WE    && !(ZERO_R0 != 0 && bus.WA == '0);
    alloc_ok = bus.ALLOC && !(ZERO_R0 != 0 && bus.ALLOC_A == '0);
    busy_nxt = busy;
    if (we_ok)    busy_nxt[bus.WA]      = 1'b0;
    if (alloc_ok) busy_nxt[bus.ALLOC_A] = 1'b1;
    rd1 = (we_ok && bus.WA == bus.RA1) ? bus.WD : mem[bus.RA1];
    rd2 = (we_ok && bus.WA == bus.RA2) ? bus.WD : mem[bus.RA2];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem <= {NREG{RESET_VAL}};
      if (ZERO_R0 != 0) mem[0] <= '0;
      busy         <= '0;
      bus.R1       <= '0;
      bus.R2       <= '0;
      bus.B1       <= 1'b0;
      bus.B2       <= 1'b0;
      bus.ANY_BUSY <= 1'b0;
    end else begin
      if (we_ok) mem[bus.WA] <= bus.WD;
      busy         <= busy_nxt;
      bus.R1       <= rd1;
      bus.R2       <= rd2;
      bus.B1       <= busy_nxt[bus.RA1];
      bus.B2       <= busy_nxt[bus.RA2];
      bus.ANY_BUSY <= |busy_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - vector table, corner sequences and random model check for regfile_sb
module tb_regfile_sb;
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  regfile_sb_if #(.DATA_W(8),  .ADDR_W(3)) ifa ();
  regfile_sb_if #(.DATA_W(8),  .ADDR_W(3)) ifz ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) ifw ();

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(0), .RESET_VAL(8'h00))
    u_a (.CLK(CLK), .RST_N(RST_N), .bus(ifa));
  regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1), .RESET_VAL(8'h00))
    u_z (.CLK(CLK), .RST_N(RST_N), .bus(ifz));
  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .RESET_VAL(16'hBEEF))
    u_w (.CLK(CLK), .RST_N(RST_N), .bus(ifw));

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       alloc;
    logic [2:0] aa;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] r1;
    logic [7:0] r2;
    logic       b1;
    logic       b2;
    logic       any;
  } vec_t;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       alloc;
    logic [2:0] aa;
    logic [2:0] ra1;
    logic [2:0] ra2;
  } stim_t;

  int vec_cnt = 0;
  int err_cnt = 0;
  vec_t tbl[10];

  // Reference state: index 0 models u_a, index 1 models u_z (hardwired entry 0).
  logic [7:0] m_mem [2][8];
  logic       m_busy[2][8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all();
    ifa.WE = 0; ifa.WA = 0; ifa.WD = 0; ifa.ALLOC = 0; ifa.ALLOC_A = 0; ifa.RA1 = 0; ifa.RA2 = 0;
    ifz.WE = 0; ifz.WA = 0; ifz.WD = 0; ifz.ALLOC = 0; ifz.ALLOC_A = 0; ifz.RA1 = 0; ifz.RA2 = 0;
    ifw.WE = 0; ifw.WA = 0; ifw.WD = 0; ifw.ALLOC = 0; ifw.ALLOC_A = 0; ifw.RA1 = 0; ifw.RA2 = 0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i]  = 8'h00;
        m_busy[k][i] = 1'b0;
      end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_all();
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    model_clear();
  endtask

  // Apply one edge of stimulus to the model: write clears, alloc sets afterwards so alloc wins.
  task automatic model_step(input int k, input stim_t s);
    bit zero = (k == 1);
    if (s.we && !(zero && s.wa == 0)) begin
      m_mem[k][s.wa]  = s.wd;
      m_busy[k][s.wa] = 1'b0;
    end
    if (s.alloc && !(zero && s.aa == 0)) m_busy[k][s.aa] = 1'b1;
  endtask

  function automatic logic model_any(input int k);
    logic a = 1'b0;
    for (int i = 0; i < 8; i++) a |= m_busy[k][i];
    return a;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.we    = 1'($urandom_range(0, 1));
    s.wa    = 3'($urandom_range(0, 7));
    s.wd    = 8'($urandom);
    s.alloc = ($urandom_range(0, 2) == 0);
    s.aa    = 3'($urandom_range(0, 7));
    s.ra1   = 3'($urandom_range(0, 7));
    s.ra2   = 3'($urandom_range(0, 7));
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t sa, sz;
    RST_N = 1'b0;
    idle_all();
    model_clear();

    //          we wa  wd     al aa ra1 ra2 r1     r2     b1 b2 any
    tbl[0] = '{0, 0, 8'h00, 0, 0, 5, 7, 8'h00, 8'h00, 0, 0, 0};
    tbl[1] = '{1, 3, 8'hA5, 0, 0, 0, 3, 8'h00, 8'hA5, 0, 0, 0};
    tbl[2] = '{0, 0, 8'h00, 0, 0, 3, 3, 8'hA5, 8'hA5, 0, 0, 0};
    tbl[3] = '{1, 6, 8'h3C, 0, 0, 6, 6, 8'h3C, 8'h3C, 0, 0, 0};
    tbl[4] = '{0, 0, 8'h00, 0, 0, 6, 6, 8'h3C, 8'h3C, 0, 0, 0};
    tbl[5] = '{0, 0, 8'h00, 1, 2, 2, 6, 8'h00, 8'h3C, 1, 0, 1};
    tbl[6] = '{1, 2, 8'h11, 0, 0, 2, 6, 8'h11, 8'h3C, 0, 0, 0};
    tbl[7] = '{1, 4, 8'h77, 1, 4, 4, 4, 8'h77, 8'h77, 1, 1, 1};
    tbl[8] = '{1, 4, 8'h55, 1, 5, 4, 5, 8'h55, 8'h00, 0, 1, 1};
    tbl[9] = '{1, 1, 8'h09, 1, 5, 5, 1, 8'h00, 8'h09, 1, 0, 1};

    #12;
    chk("rst.R1", ifa.R1, 0);
    chk("rst.ANY", ifa.ANY_BUSY, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 10; i++) begin
      ifa.WE = tbl[i].we; ifa.WA = tbl[i].wa; ifa.WD = tbl[i].wd;
      ifa.ALLOC = tbl[i].alloc; ifa.ALLOC_A = tbl[i].aa;
      ifa.RA1 = tbl[i].ra1; ifa.RA2 = tbl[i].ra2;
      tick();
      chk($sformatf("vec%0d.R1", i), ifa.R1, tbl[i].r1);
      chk($sformatf("vec%0d.R2", i), ifa.R2, tbl[i].r2);
      chk($sformatf("vec%0d.B1", i), ifa.B1, tbl[i].b1);
      chk($sformatf("vec%0d.B2", i), ifa.B2, tbl[i].b2);
      chk($sformatf("vec%0d.ANY", i), ifa.ANY_BUSY, tbl[i].any);
    end

    // Asynchronous reset between edges clears outputs immediately.
    idle_all();
    #2;
    RST_N = 1'b0;
    #1;
    chk("async.R2", ifa.R2, 0);
    chk("async.B1", ifa.B1, 0);
    chk("async.ANY", ifa.ANY_BUSY, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    ifa.RA1 = 5; ifa.RA2 = 7;
    tick();
    chk("post_rst.R1", ifa.R1, 0);
    chk("post_rst.R2", ifa.R2, 0);

    // Hardwired-zero build.
    ifz.WE = 1; ifz.WA = 0; ifz.WD = 8'hFF; ifz.ALLOC = 1; ifz.ALLOC_A = 0; ifz.RA1 = 0; ifz.RA2 = 0;
    tick();
    chk("z0.R1", ifz.R1, 0);
    chk("z0.B1", ifz.B1, 0);
    chk("z0.ANY", ifz.ANY_BUSY, 0);
    ifz.WE = 0; ifz.ALLOC = 0;
    tick();
    chk("z0b.R2", ifz.R2, 0);
    chk("z0b.B2", ifz.B2, 0);
    ifz.WE = 1; ifz.WA = 1; ifz.WD = 8'h12; ifz.RA1 = 1;
    tick();
    chk("z1fwd.R1", ifz.R1, 8'h12);
    ifz.WE = 0;
    tick();
    chk("z1.R1", ifz.R1, 8'h12);

    // Wide build: every entry resets to 0xBEEF.
    for (int i = 0; i < 16; i++) begin
      ifw.RA1 = 4'(i); ifw.RA2 = 4'(15 - i);
      tick();
      chk($sformatf("w%0d.R1", i), ifw.R1, 16'hBEEF);
      chk($sformatf("w%0d.R2", i), ifw.R2, 16'hBEEF);
    end

    // Mid-operation reset: entry 5 = 0x44 busy, then reset lands on a write of 0x99.
    ifa.WE = 1; ifa.WA = 5; ifa.WD = 8'h44; ifa.ALLOC = 1; ifa.ALLOC_A = 5; ifa.RA1 = 5;
    ifw.WE = 1; ifw.WA = 5; ifw.WD = 16'h1234; ifw.ALLOC = 1; ifw.ALLOC_A = 5; ifw.RA1 = 5;
    tick();
    chk("mid.pre.R1", ifa.R1, 8'h44);
    chk("mid.pre.B1", ifa.B1, 1);
    chk("midw.pre.R1", ifw.R1, 16'h1234);
    ifa.ALLOC = 0; ifa.WD = 8'h99;
    ifw.ALLOC = 0; ifw.WD = 16'h9999;
    #2;
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    idle_all();
    ifa.RA1 = 5; ifa.RA2 = 5;
    tick();
    chk("mid.R1", ifa.R1, 8'h00);
    chk("mid.B1", ifa.B1, 0);
    chk("mid.ANY", ifa.ANY_BUSY, 0);
    for (int i = 0; i < 16; i++) begin
      ifw.RA1 = 4'(i); ifw.RA2 = 4'(i);
      tick();
      chk($sformatf("midw%0d.R1", i), ifw.R1, 16'hBEEF);
      chk($sformatf("midw%0d.B2", i), ifw.B2, 0);
    end
    chk("midw.ANY", ifw.ANY_BUSY, 0);

    // Random traffic on both 8-bit builds against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sa = rand_stim();
      sz = rand_stim();
      ifa.WE = sa.we; ifa.WA = sa.wa; ifa.WD = sa.wd; ifa.ALLOC = sa.alloc; ifa.ALLOC_A = sa.aa;
      ifa.RA1 = sa.ra1; ifa.RA2 = sa.ra2;
      ifz.WE = sz.we; ifz.WA = sz.wa; ifz.WD = sz.wd; ifz.ALLOC = sz.alloc; ifz.ALLOC_A = sz.aa;
      ifz.RA1 = sz.ra1; ifz.RA2 = sz.ra2;
      tick();
      model_step(0, sa);
      model_step(1, sz);
      chk($sformatf("rnd%0d.a.R1", n), ifa.R1, m_mem[0][sa.ra1]);
      chk($sformatf("rnd%0d.a.R2", n), ifa.R2, m_mem[0][sa.ra2]);
      chk($sformatf("rnd%0d.a.B1", n), ifa.B1, m_busy[0][sa.ra1]);
      chk($sformatf("rnd%0d.a.B2", n), ifa.B2, m_busy[0][sa.ra2]);
      chk($sformatf("rnd%0d.a.ANY", n), ifa.ANY_BUSY, model_any(0));
      chk($sformatf("rnd%0d.z.R1", n), ifz.R1, (sz.ra1 == 0) ? 8'h00 : m_mem[1][sz.ra1]);
      chk($sformatf("rnd%0d.z.R2", n), ifz.R2, (sz.ra2 == 0) ? 8'h00 : m_mem[1][sz.ra2]);
      chk($sformatf("rnd%0d.z.B1", n), ifz.B1, (sz.ra1 == 0) ? 1'b0 : m_busy[1][sz.ra1]);
      chk($sformatf("rnd%0d.z.B2", n), ifz.B2, (sz.ra2 == 0) ? 1'b0 : m_busy[1][sz.ra2]);
      chk($sformatf("rnd%0d.z.ANY", n), ifz.ANY_BUSY, model_any(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
